// File: rtl/mvm_seq_pkg.sv
// Shared types and sizing helpers for the mvm command sequencer.
// Imported by mvm_sequencer and mvm_seq_fifo.
package mvm_seq_pkg;

    localparam int SEQ_STATE_W = 3;

    typedef enum logic [1:0] {
        OP_LOAD_M  = 2'd0,
        OP_LOAD_V  = 2'd1,
        OP_COMPUTE = 2'd2,
        OP_NOP     = 2'd3
    } cmd_op_e;

    typedef enum logic [SEQ_STATE_W-1:0] {
        S_IDLE       = 3'd0,
        S_FILL       = 3'd1,
        S_PULSE      = 3'd2,
        S_BURST      = 3'd3,
        S_WAIT_SPACE = 3'd4,
        S_START      = 3'd5,
        S_WAIT_DONE  = 3'd6,
        S_CAPTURE    = 3'd7
    } seq_state_e;

    // The stage buffer must hold a whole matrix; the counter must also reach N*N.
    function automatic int stage_depth(input int n);
        return n * n;
    endfunction

    function automatic int count_width(input int n);
        return $clog2(n * n + 1);
    endfunction

    function automatic int index_width(input int n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

endpackage

// File: rtl/mvm_seq_fifo.sv
// Synchronous FIFO holding mvm result words until the consumer takes them.
// Same-cycle push and pop are allowed; the read word reads as zero while empty.
module mvm_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_SLOT  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mvm_sequencer.sv
// Command-driven controller for one mvm: stages matrix/vector words, replays them as gap-free bursts,
// triggers compute and buffers results. Define MVM_SEQ_AUTO_START_EN to start compute after a vector load.
module mvm_sequencer
    import mvm_seq_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int OW = 2 * W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [W-1:0]  s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [OW-1:0] m_data,
    output logic          mvm_loadMatrix,
    output logic          mvm_loadVector,
    output logic          mvm_start,
    output logic [W-1:0]  mvm_data_in,
    input  logic          mvm_done,
    input  logic [OW-1:0] mvm_data_out,
    output logic          err
);

    localparam int K_MAT = stage_depth(N);
    localparam int CW    = count_width(N);
    localparam int IW    = index_width(N);
    localparam logic [CW-1:0] LAST_MAT = CW'(K_MAT - 1);
    localparam logic [CW-1:0] LAST_VEC = CW'(N - 1);

    seq_state_e     state;
    cmd_op_e        op;
    logic           load_vec;
    logic [CW-1:0]  count;
    logic [IW-1:0]  idx;
    logic [W-1:0]   stage [K_MAT];
    logic           mat_ok;
    logic           vec_ok;
    logic           cmd_fire;
    logic           s_fire;
    logic           last_word;
    logic           capture;
    logic           fifo_empty;

    assign op        = cmd_op_e'(cmd_op);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign s_fire    = s_valid && s_ready;
    assign idx       = count[IW-1:0];
    assign last_word = (count == (load_vec ? LAST_VEC : LAST_MAT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            load_vec <= 1'b0;
            count    <= '0;
            mat_ok   <= 1'b0;
            vec_ok   <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        case (op)
                            OP_LOAD_M: begin
                                load_vec <= 1'b0;
                                count    <= '0;
                                state    <= S_FILL;
                            end
                            OP_LOAD_V: begin
                                load_vec <= 1'b1;
                                count    <= '0;
                                state    <= S_FILL;
                            end
                            OP_COMPUTE: begin
                                if (mat_ok && vec_ok) begin
                                    state <= S_WAIT_SPACE;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                S_FILL: begin
                    if (s_fire) begin
                        if (last_word) begin
                            count <= '0;
                            state <= S_PULSE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                S_PULSE: begin
                    state <= S_BURST;
                end
                // The mvm takes its burst on consecutive cycles, so no handshake here.
                S_BURST: begin
                    if (last_word) begin
                        count <= '0;
                        if (load_vec) begin
                            vec_ok <= 1'b1;
                        end else begin
                            mat_ok <= 1'b1;
                        end
`ifdef MVM_SEQ_AUTO_START_EN
                        state <= (load_vec && mat_ok) ? S_WAIT_SPACE : S_IDLE;
`else
                        state <= S_IDLE;
`endif
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                // An empty FIFO guarantees room for the whole unstoppable result burst.
                S_WAIT_SPACE: begin
                    if (fifo_empty) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (mvm_done) begin
                        count <= '0;
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (count == LAST_VEC) begin
                        count <= '0;
                        state <= S_IDLE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_FILL && s_fire) begin
            stage[idx] <= s_data;
        end
    end

    assign cmd_ready      = (state == S_IDLE);
    assign s_ready        = (state == S_FILL);
    assign mvm_loadMatrix = (state == S_PULSE) && !load_vec;
    assign mvm_loadVector = (state == S_PULSE) && load_vec;
    assign mvm_start      = (state == S_START);
    assign mvm_data_in    = (state == S_BURST) ? stage[idx] : '0;
    assign capture        = (state == S_CAPTURE);
    assign m_valid        = !fifo_empty;

    mvm_seq_fifo #(
        .DEPTH (N),
        .WIDTH (OW)
    ) result_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (capture),
        .push_data (mvm_data_out),
        .pop       (m_ready),
        .pop_data  (m_data),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_mvm_sequencer.sv
// Self-checking bench for mvm_sequencer with a behavioural mvm responder and a result/burst scoreboard.
// Covers both builds; with MVM_SEQ_AUTO_START_EN a vector load after a matrix load also produces results.
module tb_mvm_sequencer;

    localparam int N       = 4;
    localparam int W       = 8;
    localparam int OW      = 16;
    localparam int K       = N * N;
    localparam int MVM_LAT = 3;
    localparam int TMO     = 500;
    localparam logic [1:0] C_LOAD_M  = 2'd0;
    localparam logic [1:0] C_LOAD_V  = 2'd1;
    localparam logic [1:0] C_COMPUTE = 2'd2;
    localparam logic [1:0] C_NOP     = 2'd3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [W-1:0]  s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [OW-1:0] m_data;
    logic          mvm_loadMatrix;
    logic          mvm_loadVector;
    logic          mvm_start;
    logic [W-1:0]  mvm_data_in;
    logic          mvm_done = 1'b0;
    logic [OW-1:0] mvm_data_out = '0;
    logic          err;

    mvm_sequencer #(.N(N), .W(W), .OW(OW)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .mvm_loadMatrix (mvm_loadMatrix),
        .mvm_loadVector (mvm_loadVector),
        .mvm_start      (mvm_start),
        .mvm_data_in    (mvm_data_in),
        .mvm_done       (mvm_done),
        .mvm_data_out   (mvm_data_out),
        .err            (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp_burst_q[$];
    int start_seen = 0;
    int exp_starts = 0;
    bit mat_loaded = 1'b0;
    bit vec_loaded = 1'b0;
    bit exp_err = 1'b0;
    int cur_m[K];
    int cur_v[N];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got %s (t=%0t)", name, what, $time);
    endtask

    // Reference result: y[j] = sum_k M[j][k] * v[k], row-major matrix.
    function automatic int ref_y(input int j);
        int acc = 0;
        for (int k = 0; k < N; k++) begin
            acc += cur_m[j * N + k] * cur_v[k];
        end
        return acc;
    endfunction

    // Behavioural mvm: captures bursts after load pulses, answers start with done then N words.
    int mm[K];
    int vv[N];
    int yy[N];
    int mb_left = 0;
    int mb_idx = 0;
    bit mb_vec = 1'b0;
    int lat_cnt = 0;
    int out_idx = N;

    always begin
        @(negedge clk);
        #1;
        if (reset) begin
            mb_left = 0;
            lat_cnt = 0;
            out_idx = N;
            mvm_done = 1'b0;
            mvm_data_out = '0;
        end else begin
            if (mb_left > 0) begin
                if (mb_vec) vv[mb_idx] = int'($signed(mvm_data_in));
                else        mm[mb_idx] = int'($signed(mvm_data_in));
                mb_idx++;
                mb_left--;
            end
            if (mvm_loadMatrix) begin
                mb_left = K; mb_idx = 0; mb_vec = 1'b0;
            end
            if (mvm_loadVector) begin
                mb_left = N; mb_idx = 0; mb_vec = 1'b1;
            end
            mvm_done = 1'b0;
            mvm_data_out = '0;
            if (out_idx < N) begin
                mvm_data_out = OW'(yy[out_idx]);
                out_idx++;
            end
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    mvm_done = 1'b1;
                    out_idx = 0;
                end
            end
            if (mvm_start) begin
                for (int j = 0; j < N; j++) begin
                    yy[j] = 0;
                    for (int k = 0; k < N; k++) yy[j] += mm[j * N + k] * vv[k];
                end
                lat_cnt = MVM_LAT;
            end
        end
    end

    // Compare process: burst words, idle data_in, start pulses and result words every cycle.
    int cb_left = 0;

    always begin
        @(negedge clk);
        #1;
        if (reset) begin
            cb_left = 0;
        end else begin
            if (cb_left > 0) begin
                if (exp_burst_q.size() == 0) fail("burst_extra", "a burst word with none expected");
                else chk("burst_word", int'($signed(mvm_data_in)), exp_burst_q.pop_front());
                cb_left--;
            end else begin
                chk("data_in_idle", int'(mvm_data_in), 0);
            end
            if (mvm_loadMatrix) cb_left = K;
            if (mvm_loadVector) cb_left = N;
            if (mvm_start) start_seen++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) fail("result_extra", $sformatf("%0d with none expected", $signed(m_data)));
                else chk("result", int'($signed(m_data)), exp_q.pop_front());
            end
        end
    end

    task automatic send_cmd(input logic [1:0] op);
        int t = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        while (!cmd_ready && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) fail("cmd_timeout", "no cmd_ready");
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_word(input int val, input int gap);
        int t = 0;
        exp_burst_q.push_back(val);
        repeat (gap) @(negedge clk);
        s_valid = 1'b1;
        s_data = W'(val);
        while (!s_ready && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) fail("word_timeout", "no s_ready");
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!cmd_ready && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) fail("idle_timeout", "cmd_ready stuck low");
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || m_valid) && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) fail("drain_timeout", $sformatf("%0d results missing", exp_q.size()));
    endtask

    task automatic push_results();
        for (int j = 0; j < N; j++) exp_q.push_back(ref_y(j));
        exp_starts++;
    endtask

    task automatic load_matrix(input int max_gap);
        send_cmd(C_LOAD_M);
        for (int i = 0; i < K; i++) send_word(cur_m[i], int'($urandom_range(max_gap, 0)));
        mat_loaded = 1'b1;
        wait_idle();
    endtask

    task automatic load_vector(input int max_gap);
        send_cmd(C_LOAD_V);
        for (int i = 0; i < N; i++) send_word(cur_v[i], int'($urandom_range(max_gap, 0)));
        vec_loaded = 1'b1;
`ifdef MVM_SEQ_AUTO_START_EN
        if (mat_loaded) push_results();
`endif
        wait_idle();
    endtask

    task automatic compute();
        send_cmd(C_COMPUTE);
        if (mat_loaded && vec_loaded) push_results();
        else exp_err = 1'b1;
        chk("err_after_compute", int'(err), int'(exp_err));
    endtask

    task automatic check_output_reset();
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_load_m", int'(mvm_loadMatrix), 0);
        chk("rst_load_v", int'(mvm_loadVector), 0);
        chk("rst_start", int'(mvm_start), 0);
        chk("rst_data_in", int'(mvm_data_in), 0);
        chk("rst_err", int'(err), 0);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        cmd_valid = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check_output_reset();
        exp_q.delete();
        exp_burst_q.delete();
        mat_loaded = 1'b0;
        vec_loaded = 1'b0;
        exp_err = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int s0;
        int e0;
        repeat (3) @(negedge clk);
        reset_dut();

        // COMPUTE with nothing loaded only raises err.
        compute();
        chk("t3_cmd_ready_back", int'(cmd_ready), 1);
        repeat (5) @(negedge clk);
        chk("t3_no_start", start_seen, 0);
        chk("t3_err_sticky", int'(err), 1);

        // NOP is accepted and changes nothing.
        send_cmd(C_NOP);
        chk("nop_cmd_ready", int'(cmd_ready), 1);
        chk("nop_s_ready", int'(s_ready), 0);
        reset_dut();

        // Identity matrix times [1,2,3,4].
        for (int i = 0; i < K; i++) cur_m[i] = (i / N == i % N) ? 1 : 0;
        for (int i = 0; i < N; i++) cur_v[i] = i + 1;
        for (int j = 0; j < N; j++) chk("pin_identity", ref_y(j), j + 1);
        s0 = start_seen;
        e0 = exp_starts;
        load_matrix(0);
        load_vector(0);
        wait_drain();
        compute();
        wait_idle();
        wait_drain();
        chk("t1_starts", start_seen - s0, exp_starts - e0);
        chk("t1_err", int'(err), 0);

        // All -11 matrix times all 11 vector.
        for (int i = 0; i < K; i++) cur_m[i] = -11;
        for (int i = 0; i < N; i++) cur_v[i] = 11;
        chk("pin_neg", ref_y(0), -484);
        chk("pin_neg3", ref_y(3), -484);
        load_matrix(0);
        load_vector(0);
        wait_drain();
        compute();
        wait_idle();
        wait_drain();

        // Random matrix delivered with stalls on s_valid.
        for (int i = 0; i < K; i++) cur_m[i] = int'($urandom_range(127, 0)) - 64;
        for (int i = 0; i < N; i++) cur_v[i] = int'($urandom_range(127, 0)) - 64;
        load_matrix(3);
        load_vector(2);
        wait_drain();
        compute();
        wait_idle();
        wait_drain();
        chk("t5_starts", start_seen, exp_starts);

        // Full FIFO blocks a second COMPUTE until the consumer drains it.
        m_ready = 1'b0;
        compute();
        wait_idle();
        chk("t4_fifo_valid", int'(m_valid), 1);
        compute();
        repeat (20) @(negedge clk);
        chk("t4_held_starts", start_seen, exp_starts - 1);
        chk("t4_held_cmd_ready", int'(cmd_ready), 0);
        chk("t4_held_valid", int'(m_valid), 1);
        m_ready = 1'b1;
        wait_drain();
        wait_idle();
        chk("t4_starts", start_seen, exp_starts);

        // New vector alone: results only when auto-start is built in.
        for (int i = 0; i < N; i++) cur_v[i] = 5 - 3 * i;
        load_vector(0);
        repeat (20) @(negedge clk);
        wait_drain();
        chk("vload_starts", start_seen, exp_starts);
        chk("vload_m_valid", int'(m_valid), 0);

        // Reset in the middle of a matrix fill.
        send_cmd(C_LOAD_M);
        for (int i = 0; i < 5; i++) send_word(7 * i - 9, 0);
        reset_dut();
        compute();
        chk("t6_fill_no_start", start_seen, exp_starts);

        // Reset while waiting for the mvm.
        reset_dut();
        for (int i = 0; i < K; i++) cur_m[i] = i - 8;
        for (int i = 0; i < N; i++) cur_v[i] = 2 * i - 3;
        load_matrix(1);
        load_vector(0);
        wait_drain();
        s0 = start_seen;
        compute();
        begin
            int t = 0;
            while (start_seen == s0 && t < TMO) begin
                @(negedge clk);
                t++;
            end
            if (start_seen == s0) fail("t6_start_timeout", "no mvm_start");
        end
        reset_dut();
        repeat (10) @(negedge clk);
        chk("t6_no_results", int'(m_valid), 0);
        compute();
        chk("t6_err_after_reset", int'(err), 1);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
